// File: rtl/instruction_fetch_unit_if.sv
// Bus between the fetch unit, instruction memory, the redirect source and decode.
// master = fetch unit side, slave = environment side.
interface instruction_fetch_unit_if;
    logic [31:0] instruction_adress;
    logic [31:0] instruction;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        halted;

    modport master (
        output instruction_adress, if_valid, if_pc, if_instr, halted,
        input  instruction, redirect_valid, redirect_pc, id_ready
    );
    modport slave (
        input  instruction_adress, if_valid, if_pc, if_instr, halted,
        output instruction, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC register, 2-deep {pc, instr} queue towards decode,
// RUN/HALT state machine that stops on HALT_INSTR and restarts on redirect.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter logic [31:0] HALT_INSTR = 32'h00100073
) (
    input logic                       clk,
    input logic                       rst_n,
    instruction_fetch_unit_if.master  bus
);
    typedef enum logic {RUN, HALT} state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_t          state;
    logic [31:0]     pc;
    logic [1:0]      count;
    entry_t [1:0]    fifo;
    entry_t          new_e;
    logic            pop;
    logic            fetch;

    assign pop   = (count != 2'd0) && bus.id_ready;
    // A full queue can still accept a fetch when the head leaves this cycle.
    assign fetch = (state == RUN) && !bus.redirect_valid && ((count != 2'd2) || pop);

    always_comb begin
        new_e       = '0;
        new_e.pc    = pc;
        new_e.instr = bus.instruction;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            pc    <= {RESET_PC[31:2], 2'b00};
            count <= 2'd0;
            fifo  <= '0;
        end else if (bus.redirect_valid) begin
            // Redirect wins over everything: flush, retarget, no fetch this cycle.
            state <= RUN;
            pc    <= {bus.redirect_pc[31:2], 2'b00};
            count <= 2'd0;
        end else begin
            if (fetch) begin
                pc <= pc + 32'd4;
                if (bus.instruction == HALT_INSTR) state <= HALT;
            end
            case ({fetch, pop})
                2'b10: begin
                    if (count == 2'd0) fifo[0] <= new_e;
                    else               fifo[1] <= new_e;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    fifo[0] <= fifo[1];
                    count   <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        fifo[0] <= new_e;
                    end else begin
                        fifo[0] <= fifo[1];
                        fifo[1] <= new_e;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.instruction_adress = pc;
    assign bus.if_valid           = (count != 2'd0);
    assign bus.if_pc              = fifo[0].pc;
    assign bus.if_instr           = fifo[0].instr;
    assign bus.halted             = (state == HALT);
endmodule
